// File: rtl/axi4_w_gate_pkg.sv
// Shared types for the RAB W-channel gate: FSM states, queued burst decisions
// and command FIFO sizing.
package axi4_w_gate_pkg;

   localparam int DEFAULT_CMD_FIFO_DEPTH = 4;
   localparam int CMD_PTR_WIDTH          = $clog2(DEFAULT_CMD_FIFO_DEPTH);
   // Widest AXI ID a queued decision can carry; narrower IDs are zero-extended.
   localparam int CMD_ID_MAX_WIDTH       = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FWD   = 2'd1,
      DROP  = 2'd2,
      BRESP = 2'd3
   } gate_state_e;

   typedef struct packed {
      logic                        drop;
      logic [CMD_ID_MAX_WIDTH-1:0] id;
      logic [7:0]                  len;
   } cmd_entry_t;

endpackage

// File: rtl/axi4_w_gate_cmd_fifo.sv
// Show-ahead FIFO of per-burst decisions; the head entry is valid whenever
// empty is low. Flags decode the registered occupancy count.
module axi4_w_gate_cmd_fifo
   import axi4_w_gate_pkg::*;
#(
   parameter int DEPTH = DEFAULT_CMD_FIFO_DEPTH,
   parameter int PTR_W = CMD_PTR_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           push,
   input  cmd_entry_t     push_data,
   input  logic           pop,
   output cmd_entry_t     head,
   output logic           full,
   output logic           empty,
   output logic [PTR_W:0] count
);

   cmd_entry_t       mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [PTR_W:0]   count_reg;
   logic             push_ok;
   logic             pop_ok;

   // A push while full is refused even if a pop happens in the same cycle.
   assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign head    = mem[rd_ptr_reg];
   assign count   = count_reg;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/axi4_w_gate_ctrl.sv
// RAB W-channel gate: forwards or silently drops each W burst per queued AW decision.
// Define AXI_W_GATE_LEN_CHECK_EN to add the burst-length checker driving len_err.
module axi4_w_gate_ctrl
   import axi4_w_gate_pkg::*;
#(
   parameter int AXI_DATA_WIDTH = 32,
   parameter int AXI_USER_WIDTH = 2,
   parameter int AXI_ID_WIDTH   = 4,
   parameter int CMD_FIFO_DEPTH = DEFAULT_CMD_FIFO_DEPTH
) (
   input  logic                        axi4_aclk,
   input  logic                        axi4_arstn,
   input  logic                        cmd_valid,
   output logic                        cmd_ready,
   input  logic                        cmd_drop,
   input  logic [AXI_ID_WIDTH-1:0]     cmd_id,
   input  logic [7:0]                  cmd_len,
   input  logic [AXI_DATA_WIDTH-1:0]   s_axi4_wdata,
   input  logic [AXI_DATA_WIDTH/8-1:0] s_axi4_wstrb,
   input  logic                        s_axi4_wlast,
   input  logic [AXI_USER_WIDTH-1:0]   s_axi4_wuser,
   input  logic                        s_axi4_wvalid,
   output logic                        s_axi4_wready,
   output logic [AXI_DATA_WIDTH-1:0]   m_axi4_wdata,
   output logic [AXI_DATA_WIDTH/8-1:0] m_axi4_wstrb,
   output logic                        m_axi4_wlast,
   output logic [AXI_USER_WIDTH-1:0]   m_axi4_wuser,
   output logic                        m_axi4_wvalid,
   input  logic                        m_axi4_wready,
   output logic                        b_err_valid,
   input  logic                        b_err_ready,
   output logic [AXI_ID_WIDTH-1:0]     b_err_id,
   output logic                        len_err
);

   localparam int PTR_W = $clog2(CMD_FIFO_DEPTH);

   cmd_entry_t              push_entry;
   cmd_entry_t              head;
   logic                    fifo_full;
   logic                    fifo_empty;
   logic                    pop;
   logic [PTR_W:0]          unused_fifo_count;
   gate_state_e             state_reg;
   gate_state_e             state_next;
   logic [AXI_ID_WIDTH-1:0] id_reg;
   logic                    w_hs;
   logic                    unused_bits;

   assign cmd_ready = ~fifo_full;

   always_comb begin
      push_entry      = '0;
      push_entry.drop = cmd_drop;
      push_entry.id   = CMD_ID_MAX_WIDTH'(cmd_id);
`ifdef AXI_W_GATE_LEN_CHECK_EN
      push_entry.len  = cmd_len;
`endif
   end

   axi4_w_gate_cmd_fifo #(
      .DEPTH (CMD_FIFO_DEPTH),
      .PTR_W (PTR_W)
   ) u_cmd_fifo (
      .clk       (axi4_aclk),
      .rst_n     (axi4_arstn),
      .push      (cmd_valid),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (unused_fifo_count)
   );

   // Payload is wired straight through; only the valid/ready pair is gated.
   assign m_axi4_wdata = s_axi4_wdata;
   assign m_axi4_wstrb = s_axi4_wstrb;
   assign m_axi4_wlast = s_axi4_wlast;
   assign m_axi4_wuser = s_axi4_wuser;
   assign b_err_id     = id_reg;

   always_comb begin
      state_next    = state_reg;
      pop           = 1'b0;
      s_axi4_wready = 1'b0;
      m_axi4_wvalid = 1'b0;
      b_err_valid   = 1'b0;
      w_hs          = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!fifo_empty) begin
               pop        = 1'b1;
               state_next = head.drop ? DROP : FWD;
            end
         end
         FWD: begin
            m_axi4_wvalid = s_axi4_wvalid;
            s_axi4_wready = m_axi4_wready;
            w_hs          = s_axi4_wvalid & m_axi4_wready;
            if (w_hs && s_axi4_wlast) begin
               state_next = IDLE;
            end
         end
         DROP: begin
            s_axi4_wready = 1'b1;
            w_hs          = s_axi4_wvalid;
            if (w_hs && s_axi4_wlast) begin
               state_next = BRESP;
            end
         end
         BRESP: begin
            b_err_valid = 1'b1;
            if (b_err_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         state_reg <= IDLE;
         id_reg    <= '0;
      end else begin
         state_reg <= state_next;
         if (pop) begin
            id_reg <= head.id[AXI_ID_WIDTH-1:0];
         end
      end
   end

`ifdef AXI_W_GATE_LEN_CHECK_EN
   logic [7:0] len_reg;
   logic [7:0] cnt_reg;
   logic       len_err_reg;
   logic       len_mis;

   // Flags an early wlast and, separately, the first beat that runs past len.
   always_comb begin
      len_mis = 1'b0;
      if (w_hs) begin
         len_mis = s_axi4_wlast ? (cnt_reg != len_reg) : (cnt_reg == len_reg);
      end
   end

   always_ff @(posedge axi4_aclk or negedge axi4_arstn) begin
      if (!axi4_arstn) begin
         len_reg     <= '0;
         cnt_reg     <= '0;
         len_err_reg <= 1'b0;
      end else begin
         len_err_reg <= len_mis;
         if (pop) begin
            len_reg <= head.len;
            cnt_reg <= '0;
         end else if (w_hs && (cnt_reg != 8'hFF)) begin
            cnt_reg <= cnt_reg + 8'd1;
         end
      end
   end

   assign len_err     = len_err_reg;
   assign unused_bits = ^{head.id, unused_fifo_count};
`else
   assign len_err     = 1'b0;
   assign unused_bits = ^{head.id, head.len, cmd_len, unused_fifo_count};
`endif

endmodule
